// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
//   fc_seq_state_t : sequencer FSM state encoding
//   DATA_WIDTH_DEF : default activation width
//   clog2p1(n)     : bits needed to hold the values 0..n inclusive
package fc_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [2:0] {CLR, IDLE, LOAD, WAIT, DRAIN} fc_seq_state_t;

  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fc_layer_out_buf.sv
// Capture buffer for the neuron outputs of one layer.
//   clk, rst : clock, async active-high reset (clears data and mask)
//   clr      : clears the got[] mask; captured data is left as-is
//   we       : per-neuron capture strobe (caller gates out repeats)
//   wdata    : all neuron outputs, neuron i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_idx   : read index, rd_data = captured value of that neuron
//   got      : per-neuron "value captured" mask
//   all_got  : every neuron captured, counting strobes of this cycle
module fc_layer_out_buf #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_W       = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic [NUM_NEURONS-1:0]            we,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]                  rd_idx,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic [NUM_NEURONS-1:0]            got,
  output logic                              all_got
);

  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] cap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= '0;
      got   <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (clr) begin
          got[i] <= 1'b0;
        end else if (we[i]) begin
          cap_q[i] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
          got[i]   <= 1'b1;
        end
      end
    end
  end

  // Include this cycle's strobes so the FSM can leave WAIT on the same
  // cycle the last neuron reports.
  assign all_got = &(got | we);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_NEURONS; i++)
      if (rd_idx == IDX_W'(i)) rd_data = cap_q[i];
  end

endmodule

// File: rtl/fc_layer_seq.sv
// Sequencer for one fully-connected layer sharing a broadcast input bus.
// Streams an input vector to all neurons, waits for every neuron's
// outvalid (with timeout), then streams the captured results downstream.
//   clk, rst                  : clock, async active-high reset
//   start                     : begin one vector (only honoured in IDLE)
//   in_data/in_valid/in_ready : upstream activation stream
//   nrn_in/nrn_in_valid       : registered broadcast to neuron myinput
//   nrn_rst                   : synchronous reset to all neurons
//   nrn_outvalid/nrn_out      : per-neuron result, neuron i at [i*DW +: DW]
//   out_data/out_valid/out_ready : result stream to the next layer
//   busy, done, error         : status (done = pulse, error = sticky timeout)
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter int NUM_INPUTS  = 30,
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int WAIT_TMO    = 16,
  parameter int CLR_CYCLES  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_WIDTH-1:0]             nrn_in,
  output logic                              nrn_in_valid,
  output logic                              nrn_rst,
  input  logic [NUM_NEURONS-1:0]            nrn_outvalid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] nrn_out,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  localparam int IW = clog2p1(NUM_INPUTS);
  localparam int OW = clog2p1(NUM_NEURONS);
  localparam int TW = clog2p1(WAIT_TMO);
  localparam int CW = clog2p1(CLR_CYCLES);

  fc_seq_state_t state, state_nxt;

  logic [IW-1:0]          in_cnt;
  logic [OW-1:0]          out_idx;
  logic [TW-1:0]          tmo_cnt;
  logic [CW-1:0]          clr_cnt;
  logic [NUM_NEURONS-1:0] got, we;
  logic                   all_got, start_ok, in_fire, out_fire, last_out, tmo_hit;

  assign start_ok = (state == IDLE) && start;
  assign in_fire  = in_ready && in_valid;
  assign out_fire = out_valid && out_ready;
  assign last_out = out_fire && (out_idx == OW'(NUM_NEURONS - 1));
  assign tmo_hit  = (state == WAIT) && !all_got && (tmo_cnt == TW'(WAIT_TMO));
  // Only the first outvalid per neuron is captured; repeats are dropped.
  assign we       = (state == WAIT) ? (nrn_outvalid & ~got) : '0;

  fc_layer_out_buf #(
    .NUM_NEURONS(NUM_NEURONS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (OW)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state == CLR) || last_out),
    .we     (we),
    .wdata  (nrn_out),
    .rd_idx (out_idx),
    .rd_data(out_data),
    .got    (got),
    .all_got(all_got)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLR;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      CLR:     if (clr_cnt == CW'(CLR_CYCLES - 1)) state_nxt = IDLE;
      IDLE:    if (start)                          state_nxt = LOAD;
      LOAD:    if (in_cnt == IW'(NUM_INPUTS))      state_nxt = WAIT;
      WAIT:    if (all_got)                        state_nxt = DRAIN;
               else if (tmo_hit)                   state_nxt = CLR;
      DRAIN:   if (last_out)                       state_nxt = IDLE;
      default:                                     state_nxt = CLR;
    endcase
  end

  // State-decoded outputs. busy is masked while rst is held so every
  // status output reads 0 during reset even though the FSM sits in CLR.
  always_comb begin
    in_ready  = (state == LOAD) && (in_cnt < IW'(NUM_INPUTS));
    out_valid = (state == DRAIN);
    nrn_rst   = (state == CLR);
    busy      = (state != IDLE) && !rst;
  end

  // Counters, broadcast register and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt       <= '0;
      out_idx      <= '0;
      tmo_cnt      <= '0;
      clr_cnt      <= '0;
      nrn_in       <= '0;
      nrn_in_valid <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      clr_cnt      <= (state == CLR) ? clr_cnt + CW'(1) : '0;
      nrn_in_valid <= in_fire;
      if (in_fire) nrn_in <= in_data;
      done <= last_out;
      if (start_ok) begin
        in_cnt  <= '0;
        out_idx <= '0;
        tmo_cnt <= '0;
        error   <= 1'b0;
      end else begin
        if (in_fire)  in_cnt  <= in_cnt + IW'(1);
        if (out_fire) out_idx <= out_idx + OW'(1);
        // Hold at the limit instead of wrapping when leaving WAIT.
        if (state == WAIT && state_nxt == WAIT) tmo_cnt <= tmo_cnt + TW'(1);
        if (tmo_hit) error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Self-checking bench for fc_layer_seq (4 inputs, 3 neurons).
module tb_fc_layer_seq;
  localparam int NI = 4, NN = 3, DW = 16, TMO = 16, CLRC = 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, nrn_in_valid, nrn_rst, out_valid, busy, done, error;
  logic [DW-1:0] nrn_in, out_data;
  logic [NN-1:0] nrn_outvalid = '0;
  logic [NN-1:0][DW-1:0] nrn_out = '0;

  int total = 0, bad = 0;
  logic [DW-1:0] vec [NI];
  int            ev_off [NN];
  logic [DW-1:0] ev_val [NN];
  int            dup_off [NN];
  logic [DW-1:0] dup_val [NN];
  logic [DW-1:0] in_q [$];
  logic start_in_wait = 1'b0;

  always #5 clk = ~clk;

  fc_layer_seq #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW), .WAIT_TMO(TMO), .CLR_CYCLES(CLRC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .nrn_in(nrn_in), .nrn_in_valid(nrn_in_valid), .nrn_rst(nrn_rst),
    .nrn_outvalid(nrn_outvalid), .nrn_out(nrn_out), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done), .error(error)
  );

  // Record every broadcast pulse seen by the neurons.
  always @(negedge clk) if (nrn_in_valid) in_q.push_back(nrn_in);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic count_clr(input string tag);
    int n;
    n = 0;
    while (nrn_rst && n < 10) begin tick(); n++; end
    chk(tag, n, CLRC);
  endtask

  task automatic do_start();
    in_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_in_ready", in_ready, 1'b1);
  endtask

  task automatic send_inputs(input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      int g;
      g = 0;
      in_data  = vec[k];
      in_valid = 1'b1;
      while (!in_ready && g < 20) begin tick(); g++; end
      chk("in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("nrn_in", {nrn_in_valid, nrn_in}, {1'b1, vec[k]});
      if (gap) begin tick(); chk("nrn_in_gap", nrn_in_valid, 1'b0); end
    end
  endtask

  // Drive neuron outvalids per ev_off/dup_off; the layer is complete at the
  // latest first-arrival offset, and DRAIN must follow that cycle.
  task automatic run_wait();
    int d;
    d = 0;
    for (int i = 0; i < NN; i++) if (ev_off[i] > d) d = ev_off[i];
    for (int t = 0; t <= d; t++) begin
      start = start_in_wait;
      for (int i = 0; i < NN; i++) begin
        nrn_outvalid[i] = (ev_off[i] == t) || (dup_off[i] == t);
        nrn_out[i]      = (ev_off[i] == t) ? ev_val[i] : dup_val[i];
      end
      if (t == d) chk("pre_drain_ov", out_valid, 1'b0);
      tick();
    end
    nrn_outvalid = '0;
    start = 1'b0;
    chk("drain_entry", out_valid, 1'b1);
  endtask

  // Expected stream: first captured value of each neuron, in index order.
  task automatic drain(input int sidx, input int slen);
    int n, s;
    n = 0; s = 0;
    while (n < NN) begin
      chk("out_valid", out_valid, 1'b1);
      chk("out_data", out_data, ev_val[n]);
      if (n == sidx && s < slen) begin out_ready = 1'b0; s++; end
      else begin out_ready = 1'b1; n++; end
      tick();
    end
    out_ready = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("ov_after", out_valid, 1'b0);
    tick();
    chk("done_low", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic check_in_q();
    chk("in_pulse_cnt", in_q.size(), NI);
    for (int i = 0; i < NI; i++)
      if (i < in_q.size()) chk("in_pulse_val", in_q[i], vec[i]);
  endtask

  task automatic full_vector(input bit gap, input int sidx, input int slen);
    do_start();
    send_inputs(NI, gap);
    chk("in_ready_full", in_ready, 1'b0);
    tick();
    run_wait();
    drain(sidx, slen);
    check_in_q();
  endtask

  task automatic set_fixed();
    for (int i = 0; i < NN; i++) begin
      ev_off[i] = 0; ev_val[i] = DW'((i + 1) * 16'h0100); dup_off[i] = -1; dup_val[i] = '0;
    end
  endtask

  initial begin
    int n;
    bit saw_ov;
    // 1 reset
    tick(); tick();
    chk("rst_nrn_rst", nrn_rst, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_nrn_in_valid", nrn_in_valid, 1'b0);
    rst = 1'b0;
    count_clr("clr_after_rst");
    chk("idle_busy0", busy, 1'b0);
    chk("idle_in_ready0", in_ready, 1'b0);
    chk("idle_out_valid0", out_valid, 1'b0);

    // 2 nominal, back-to-back inputs
    for (int k = 0; k < NI; k++) vec[k] = DW'($urandom);
    set_fixed();
    full_vector(1'b0, -1, 0);

    // 3 gapped inputs, output stalled 3 cycles on idx1
    for (int k = 0; k < NI; k++) vec[k] = DW'($urandom);
    full_vector(1'b1, 1, 3);

    // 4 skewed and duplicate outvalid
    for (int k = 0; k < NI; k++) vec[k] = DW'($urandom);
    set_fixed();
    ev_off[2] = 1; ev_off[0] = 3; ev_off[1] = 5;
    for (int i = 0; i < NN; i++) ev_val[i] = DW'($urandom);
    dup_off[0] = 4; dup_val[0] = 16'hFFFF;
    full_vector(1'b0, -1, 0);

    // 5 timeout: neuron1 never answers
    for (int k = 0; k < NI; k++) vec[k] = DW'($urandom);
    do_start();
    send_inputs(NI, 1'b0);
    tick();
    nrn_outvalid = 3'b101;
    nrn_out = '1;
    tick();
    nrn_outvalid = '0;
    n = 1; saw_ov = 1'b0;
    while (!error && n < 40) begin saw_ov |= out_valid; tick(); n++; end
    chk("tmo_cycles", n, TMO + 1);
    chk("tmo_no_out", saw_ov, 1'b0);
    count_clr("clr_after_tmo");
    chk("tmo_error_sticky", error, 1'b1);
    chk("tmo_idle", busy, 1'b0);
    do_start();
    chk("error_cleared", error, 1'b0);

    // 6 mid-operation reset after 2 inputs, then a clean vector
    for (int k = 0; k < NI; k++) vec[k] = DW'($urandom);
    send_inputs(2, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_nrn_rst", nrn_rst, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    count_clr("clr_after_midrst");
    for (int i = 0; i < NN; i++) ev_val[i] = DW'($urandom);
    start_in_wait = 1'b1;
    full_vector(1'b0, 0, 1);
    start_in_wait = 1'b0;
    chk("start_ignored_in_ready", in_ready, 1'b0);

    // randomized vectors
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NI; k++) vec[k] = DW'($urandom);
      for (int i = 0; i < NN; i++) begin
        ev_off[i]  = $urandom_range(0, 6);
        ev_val[i]  = DW'($urandom);
        dup_off[i] = ($urandom_range(0, 1) == 1) ? ev_off[i] + 1 : -1;
        dup_val[i] = DW'($urandom);
      end
      full_vector(1'($urandom_range(0, 1)), $urandom_range(0, NN - 1), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
